// File: rtl/pixel_map_scanner_pkg.sv
// pixel_map_scanner_pkg: bitmap geometry, output geometry and the scanner state type.
// Output geometry follows SCANNER_SCALE2X_EN (2x replication when defined).
package pixel_map_scanner_pkg;

    localparam int GLYPH_DIM = 12;
    localparam int MAP_ROWS  = GLYPH_DIM;
    localparam int MAP_COLS  = 120;
    localparam int MAP_BITS  = MAP_ROWS * MAP_COLS;

`ifdef SCANNER_SCALE2X_EN
    localparam int SCALE_SHIFT = 1;
`else
    localparam int SCALE_SHIFT = 0;
`endif

    localparam int OUT_COLS = MAP_COLS << SCALE_SHIFT;
    localparam int OUT_ROWS = MAP_ROWS << SCALE_SHIFT;

    localparam int X_W   = 8;
    localparam int Y_W   = 5;
    localparam int IDX_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    // Row 0 / column 0 lives in the MSB of the map, so the index counts down.
    function automatic logic [IDX_W-1:0] src_bit_index(input logic [X_W-1:0] x,
                                                       input logic [Y_W-1:0] y);
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        row = IDX_W'(y >> SCALE_SHIFT);
        col = IDX_W'(x >> SCALE_SHIFT);
        return IDX_W'(MAP_BITS - 1) - (row * IDX_W'(MAP_COLS) + col);
    endfunction

endpackage

// File: rtl/pixel_map_scanner.sv
// pixel_map_scanner: captures a 12x120 bitmap on load and streams it out row-major.
// Define SCANNER_SCALE2X_EN to replicate every source pixel 2x2 (240x24 output).
module pixel_map_scanner
    import pixel_map_scanner_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                load,
    input  logic [MAP_BITS-1:0] pixel_map,
    output logic                busy,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                pix_data,
    output logic [X_W-1:0]      pix_x,
    output logic [Y_W-1:0]      pix_y,
    output logic                pix_last,
    output logic                frame_done,
    output scan_state_e         state_dbg
);

    localparam logic [X_W-1:0] X_MAX = X_W'(OUT_COLS - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(OUT_ROWS - 1);

    scan_state_e         state_q, state_d;
    logic [MAP_BITS-1:0] map_q, map_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic                data_q, data_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            map_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Handshake: a beat moves on a rising edge where pix_valid && pix_ready; while
    // pix_valid is high and pix_ready low, data/x/y/last are held unchanged.
    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SCAN;
                    map_d   = pixel_map;
                    x_d     = '0;
                    y_d     = '0;
                    data_d  = pixel_map[MAP_BITS-1];
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (pix_ready) begin
                    if (x_q == X_MAX && y_q == Y_MAX) begin
                        state_d = DONE;
                        x_d     = '0;
                        y_d     = '0;
                        data_d  = 1'b0;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (x_q == X_MAX) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        data_d = map_q[src_bit_index(x_d, y_d)];
                        last_d = (x_d == X_MAX);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign pix_valid  = valid_q;
    assign pix_data   = data_q;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign pix_last   = last_q;
    assign frame_done = done_q;
    assign state_dbg  = state_q;

endmodule
